mutation_lane_sequencer: RTL

Controller that runs the add-node/add-connection mutation lane over one genome. It fetches genes from genome memory and issues them one at a time to the lane, driving the lane's setup, state and global node-max inputs. It captures the lane's 1–3 output genes and serialises them into the child-genome write port. It also carries the running hidden-node maximum across the genome and reports it on completion.

---
 rtl/mutation_lane_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mutation_lane_sequencer.sv
// Sequences one genome through the add-node/add-connection mutation lane:
// fetch -> issue -> capture -> drain of up to three child genes per parent gene.
module mutation_lane_sequencer #(
    parameter int unsigned GENE_SZ = 64,
    parameter int unsigned ATTR_SZ = 8,
    parameter int unsigned ADDR_W  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mutate_en,
    input  logic [ATTR_SZ-1:0] genome_id_in,
    input  logic [ADDR_W-1:0]  gene_count,
    input  logic [ADDR_W-1:0]  rd_base,
    input  logic [ADDR_W-1:0]  wr_base,
    input  logic [ATTR_SZ-1:0] init_hidden_max,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic [GENE_SZ-1:0] mem_rd_data,
    output logic               lane_setup,
    output logic               lane_state,
    output logic [GENE_SZ-1:0] lane_gene_in,
    output logic [ATTR_SZ-1:0] lane_genome_id,
    output logic [ATTR_SZ-1:0] lane_global_max,
    input  logic [ATTR_SZ-1:0] lane_hidden_max,
    input  logic [GENE_SZ-1:0] lane_gene1,
    input  logic [GENE_SZ-1:0] lane_gene2,
    input  logic [GENE_SZ-1:0] lane_gene3,
    input  logic [2:0]         lane_valid,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [GENE_SZ-1:0] wr_data,
    input  logic               wr_ready,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  out_count,
    output logic [ATTR_SZ-1:0] hidden_max
);

    typedef enum logic [2:0] {
        IDLE, SETUP, FETCH, ISSUE, CAPTURE, DRAIN, DONE
    } state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W-1:0]   count_r;
    logic [ADDR_W-1:0]   rd_base_r;
    logic [ADDR_W-1:0]   wr_base_r;
    logic                mutate_r;
    logic [GENE_SZ-1:0]  slot0, slot1, slot2;
    logic [2:0]          slot_v;
    logic [1:0]          sel;
    logic                pending;
    logic                accept;
    logic [2:0]          remaining;
    logic                last_gene;

    // Lowest-numbered pending slot goes out first.
    always_comb begin
        sel = 2'd2;
        if (slot_v[0])      sel = 2'd0;
        else if (slot_v[1]) sel = 2'd1;
    end

    assign pending   = |slot_v;
    assign accept    = (state == DRAIN) && pending && wr_ready;
    assign remaining = accept ? (slot_v & ~(3'b001 << sel)) : slot_v;
    assign last_gene = (ADDR_W'(idx + ADDR_W'(1)) == count_r);
    assign lane_global_max = hidden_max;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next state and state-decoded lane/memory/write strobes.
    always_comb begin
        state_next   = state;
        mem_rd_en    = 1'b0;
        mem_rd_addr  = '0;
        lane_setup   = 1'b0;
        lane_state   = 1'b0;
        lane_gene_in = '0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        done         = 1'b0;
        busy         = (state != IDLE);
        case (state)
            IDLE: if (start) state_next = SETUP;
            SETUP: begin
                lane_setup = 1'b1;
                state_next = (count_r == '0) ? DONE : FETCH;
            end
            FETCH: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = ADDR_W'(rd_base_r + idx);
                state_next  = ISSUE;
            end
            ISSUE: begin
                lane_gene_in = mem_rd_data;
                lane_state   = mutate_r;
                state_next   = CAPTURE;
            end
            CAPTURE: state_next = DRAIN;
            DRAIN: begin
                wr_en   = pending;
                wr_addr = ADDR_W'(wr_base_r + out_count);
                if (pending) begin
                    case (sel)
                        2'd0:    wr_data = slot0;
                        2'd1:    wr_data = slot1;
                        default: wr_data = slot2;
                    endcase
                end
                if (remaining == 3'b000) state_next = last_gene ? DONE : FETCH;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Pass context, capture buffer and running counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx            <= '0;
            count_r        <= '0;
            rd_base_r      <= '0;
            wr_base_r      <= '0;
            mutate_r       <= 1'b0;
            lane_genome_id <= '0;
            out_count      <= '0;
            hidden_max     <= '0;
            slot0          <= '0;
            slot1          <= '0;
            slot2          <= '0;
            slot_v         <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    idx            <= '0;
                    count_r        <= gene_count;
                    rd_base_r      <= rd_base;
                    wr_base_r      <= wr_base;
                    mutate_r       <= mutate_en;
                    lane_genome_id <= genome_id_in;
                    out_count      <= '0;
                    hidden_max     <= init_hidden_max;
                end
                CAPTURE: begin
                    slot0      <= lane_gene1;
                    slot1      <= lane_gene2;
                    slot2      <= lane_gene3;
                    slot_v     <= lane_valid;
                    hidden_max <= lane_hidden_max;
                end
                DRAIN: begin
                    slot_v <= remaining;
                    if (accept) out_count <= ADDR_W'(out_count + ADDR_W'(1));
                    if (remaining == 3'b000) idx <= ADDR_W'(idx + ADDR_W'(1));
                end
                default: ;
            endcase
        end
    end

endmodule
